// File: rtl/mips_regfile_wb.sv
// MIPS 32x32 general-purpose register file with write-back bypass
// and a per-register load-pending scoreboard for load-use stalls.
module mips_regfile_wb #(
    parameter int DATA_W = 32,
    parameter int NREG   = 32,
    parameter int ADDR_W = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [ADDR_W-1:0] rs_addr,
    input  logic [ADDR_W-1:0] rt_addr,
    output logic [DATA_W-1:0] rs_data,
    output logic [DATA_W-1:0] rt_data,
    input  logic              wb_en,
    input  logic [ADDR_W-1:0] wb_addr,
    input  logic [DATA_W-1:0] wb_data,
    input  logic              pend_set,
    input  logic [ADDR_W-1:0] pend_addr,
    output logic              rs_pending,
    output logic              rt_pending,
    output logic              pend_any
);

    logic [DATA_W-1:0] regs [NREG];
    logic [NREG-1:0]   pend;
    logic [NREG-1:0]   pend_nxt;
    logic              wb_live;
    logic              rs_hit;
    logic              rt_hit;

    assign wb_live = wb_en && (wb_addr != '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREG; i++) begin
                regs[i] <= '0;
            end
            pend <= '0;
        end else begin
            if (wb_live) begin
                regs[wb_addr] <= wb_data;
            end
            pend <= pend_nxt;
        end
    end

    // A new load mark beats a retiring write to the same register.
    always_comb begin
        pend_nxt = pend;
        if (wb_en) begin
            pend_nxt[wb_addr] = 1'b0;
        end
        if (pend_set) begin
            pend_nxt[pend_addr] = 1'b1;
        end
        pend_nxt[0] = 1'b0;
    end

    assign rs_hit = wb_en && (wb_addr == rs_addr);
    assign rt_hit = wb_en && (wb_addr == rt_addr);

    always_comb begin
        rs_data = '0;
        rt_data = '0;
        if (rs_addr != '0) begin
            rs_data = rs_hit ? wb_data : regs[rs_addr];
        end
        if (rt_addr != '0) begin
            rt_data = rt_hit ? wb_data : regs[rt_addr];
        end
    end

    // A register being written back now is served by the bypass.
    assign rs_pending = pend[rs_addr] && !rs_hit;
    assign rt_pending = pend[rt_addr] && !rt_hit;
    assign pend_any   = |pend;

endmodule

// File: tb/tb_mips_regfile_wb.sv
// Scoreboard bench for mips_regfile_wb: stimulus queues expectations,
// a negedge monitor pops and compares them against the live outputs.
module tb_mips_regfile_wb;

    localparam logic [4:0] M_RSD = 5'b00001;
    localparam logic [4:0] M_RTD = 5'b00010;
    localparam logic [4:0] M_RSP = 5'b00100;
    localparam logic [4:0] M_RTP = 5'b01000;
    localparam logic [4:0] M_PA  = 5'b10000;
    localparam logic [4:0] M_ALL = 5'b11111;

    typedef struct {
        string       name;
        logic [4:0]  m;
        logic [31:0] rsd;
        logic [31:0] rtd;
        logic        rsp;
        logic        rtp;
        logic        pa;
    } exp_t;

    logic        clk;
    logic        rst_n;
    logic [4:0]  rs_addr;
    logic [4:0]  rt_addr;
    logic [31:0] rs_data;
    logic [31:0] rt_data;
    logic        wb_en;
    logic [4:0]  wb_addr;
    logic [31:0] wb_data;
    logic        pend_set;
    logic [4:0]  pend_addr;
    logic        rs_pending;
    logic        rt_pending;
    logic        pend_any;

    exp_t q[$];
    int   errors = 0;
    int   checks = 0;

    mips_regfile_wb dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .rs_addr    (rs_addr),
        .rt_addr    (rt_addr),
        .rs_data    (rs_data),
        .rt_data    (rt_data),
        .wb_en      (wb_en),
        .wb_addr    (wb_addr),
        .wb_data    (wb_data),
        .pend_set   (pend_set),
        .pend_addr  (pend_addr),
        .rs_pending (rs_pending),
        .rt_pending (rt_pending),
        .pend_any   (pend_any)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: sim time expired, pending=%0d", q.size());
        $fatal(1, "watchdog");
    end

    // Monitor: outputs are stable mid-cycle, sampled on the falling edge.
    always @(negedge clk) begin
        exp_t e;
        if (q.size() > 0) begin
            e = q.pop_front();
            if (e.m[0]) begin
                checks++;
                if (rs_data !== e.rsd) begin
                    errors++;
                    $display("FAIL %s rs_data got=%h exp=%h",
                             e.name, rs_data, e.rsd);
                end
            end
            if (e.m[1]) begin
                checks++;
                if (rt_data !== e.rtd) begin
                    errors++;
                    $display("FAIL %s rt_data got=%h exp=%h",
                             e.name, rt_data, e.rtd);
                end
            end
            if (e.m[2]) begin
                checks++;
                if (rs_pending !== e.rsp) begin
                    errors++;
                    $display("FAIL %s rs_pending got=%b exp=%b",
                             e.name, rs_pending, e.rsp);
                end
            end
            if (e.m[3]) begin
                checks++;
                if (rt_pending !== e.rtp) begin
                    errors++;
                    $display("FAIL %s rt_pending got=%b exp=%b",
                             e.name, rt_pending, e.rtp);
                end
            end
            if (e.m[4]) begin
                checks++;
                if (pend_any !== e.pa) begin
                    errors++;
                    $display("FAIL %s pend_any got=%b exp=%b",
                             e.name, pend_any, e.pa);
                end
            end
        end
    end

    task automatic step(input logic [4:0] rs, input logic [4:0] rt,
                        input logic we, input logic [4:0] wa,
                        input logic [31:0] wd, input logic ps,
                        input logic [4:0] pa);
        @(posedge clk);
        #1;
        rs_addr   = rs;
        rt_addr   = rt;
        wb_en     = we;
        wb_addr   = wa;
        wb_data   = wd;
        pend_set  = ps;
        pend_addr = pa;
    endtask

    task automatic expect_out(input string n, input logic [4:0] m,
                              input logic [31:0] rsd,
                              input logic [31:0] rtd,
                              input logic rsp, input logic rtp,
                              input logic pa);
        exp_t e;
        e.name = n;
        e.m    = m;
        e.rsd  = rsd;
        e.rtd  = rtd;
        e.rsp  = rsp;
        e.rtp  = rtp;
        e.pa   = pa;
        q.push_back(e);
    endtask

    initial begin
        rst_n = 1'b0;
        step(5'd5, 5'd0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0);
        expect_out("reset_state", M_ALL, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);

        // Test 1: write reg5, then reset mid-cycle clears it at once
        step(5'd5, 5'd0, 1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0);
        rst_n = 1'b1;
        expect_out("t1_bypass5", M_RSD, 32'hDEADBEEF, 32'h0,
                   1'b0, 1'b0, 1'b0);
        step(5'd5, 5'd0, 1'b0, 5'd0, 32'h0, 1'b1, 5'd6);
        expect_out("t1_stored5", M_RSD | M_PA, 32'hDEADBEEF, 32'h0,
                   1'b0, 1'b0, 1'b0);
        step(5'd5, 5'd6, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0);
        expect_out("t1_pend6", M_RTP | M_PA, 32'h0, 32'h0,
                   1'b0, 1'b1, 1'b1);
        step(5'd5, 5'd6, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0);
        rst_n = 1'b0;
        expect_out("t1_async_clr", M_ALL, 32'h0, 32'h0,
                   1'b0, 1'b0, 1'b0);
        step(5'd0, 5'd0, 1'b1, 5'd0, 32'hFFFFFFFF, 1'b0, 5'd0);
        rst_n = 1'b1;
        expect_out("t1_r0_bypass", M_RSD | M_RTD, 32'h0, 32'h0,
                   1'b0, 1'b0, 1'b0);
        step(5'd0, 5'd5, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0);
        expect_out("t1_r0_read", M_RSD | M_RTD, 32'h0, 32'h0,
                   1'b0, 1'b0, 1'b0);

        // Test 2: write then read on both ports
        step(5'd0, 5'd0, 1'b1, 5'd7, 32'h12345678, 1'b0, 5'd0);
        step(5'd7, 5'd7, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0);
        expect_out("t2_read7", M_ALL, 32'h12345678, 32'h12345678,
                   1'b0, 1'b0, 1'b0);

        // Test 3: bypass on one port, stored value on the other
        step(5'd0, 5'd0, 1'b1, 5'd9, 32'h1, 1'b0, 5'd0);
        step(5'd0, 5'd0, 1'b1, 5'd10, 32'h0000CAFE, 1'b0, 5'd0);
        step(5'd10, 5'd9, 1'b1, 5'd9, 32'hA5A5A5A5, 1'b0, 5'd0);
        expect_out("t3_bypass9", M_RSD | M_RTD, 32'h0000CAFE,
                   32'hA5A5A5A5, 1'b0, 1'b0, 1'b0);
        step(5'd9, 5'd9, 1'b1, 5'd9, 32'h5A5A5A5A, 1'b0, 5'd0);
        expect_out("t3_dual_byp", M_RSD | M_RTD, 32'h5A5A5A5A,
                   32'h5A5A5A5A, 1'b0, 1'b0, 1'b0);
        step(5'd9, 5'd10, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0);
        expect_out("t3_stored9", M_RSD | M_RTD, 32'h5A5A5A5A,
                   32'h0000CAFE, 1'b0, 1'b0, 1'b0);

        // Test 4: load-use mark and write-back release
        step(5'd3, 5'd3, 1'b0, 5'd0, 32'h0, 1'b1, 5'd3);
        expect_out("t4_set_same", M_RSP | M_RTP | M_PA, 32'h0, 32'h0,
                   1'b0, 1'b0, 1'b0);
        step(5'd3, 5'd3, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0);
        expect_out("t4_pending", M_RSP | M_RTP | M_PA, 32'h0, 32'h0,
                   1'b1, 1'b1, 1'b1);
        step(5'd3, 5'd0, 1'b1, 5'd3, 32'h42, 1'b0, 5'd0);
        expect_out("t4_wb", M_RSD | M_RSP | M_PA, 32'h42, 32'h0,
                   1'b0, 1'b0, 1'b1);
        step(5'd3, 5'd0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0);
        expect_out("t4_after", M_RSD | M_RSP | M_PA, 32'h42, 32'h0,
                   1'b0, 1'b0, 1'b0);

        // Test 5: set and clear of the same register collide
        step(5'd0, 5'd0, 1'b0, 5'd0, 32'h0, 1'b1, 5'd4);
        step(5'd4, 5'd0, 1'b1, 5'd4, 32'h77, 1'b1, 5'd4);
        expect_out("t5_collide", M_RSD | M_RSP | M_PA, 32'h77, 32'h0,
                   1'b0, 1'b0, 1'b1);
        step(5'd4, 5'd4, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0);
        expect_out("t5_set_wins", M_ALL, 32'h77, 32'h77,
                   1'b1, 1'b1, 1'b1);
        step(5'd0, 5'd0, 1'b1, 5'd4, 32'h77, 1'b1, 5'd0);
        step(5'd0, 5'd4, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0);
        expect_out("t5_r0_nopend", M_RSP | M_RTP | M_PA, 32'h0, 32'h0,
                   1'b0, 1'b0, 1'b0);

        // Test 6: sweep all registers
        for (int i = 1; i < 32; i++) begin
            step(5'd0, 5'd0, 1'b1, 5'(i), 32'(i) * 32'h01010101,
                 1'b0, 5'd0);
        end
        for (int i = 1; i < 32; i++) begin
            step(5'(i), 5'(32 - i), 1'b0, 5'd0, 32'h0, 1'b0, 5'd0);
            expect_out($sformatf("t6_read%0d", i), M_RSD | M_RTD,
                       32'(i) * 32'h01010101,
                       32'(32 - i) * 32'h01010101,
                       1'b0, 1'b0, 1'b0);
        end
        for (int i = 1; i < 32; i++) begin
            step(5'd0, 5'd0, 1'b0, 5'd0, 32'h0, 1'b1, 5'(i));
        end
        step(5'd1, 5'd31, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0);
        expect_out("t6_all_pend", M_RSP | M_RTP | M_PA, 32'h0, 32'h0,
                   1'b1, 1'b1, 1'b1);
        for (int i = 1; i < 32; i++) begin
            step(5'(i), 5'd31, 1'b1, 5'(i), 32'(i) * 32'h01010101,
                 1'b0, 5'd0);
            expect_out($sformatf("t6_clr%0d", i),
                       M_RSD | M_RSP | M_RTP | M_PA,
                       32'(i) * 32'h01010101, 32'h0,
                       1'b0, (i < 31), 1'b1);
        end
        step(5'd31, 5'd1, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0);
        expect_out("t6_drained", M_ALL, 32'h1F1F1F1F, 32'h01010101,
                   1'b0, 1'b0, 1'b0);

        @(posedge clk);
        #1;
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL drain queue left=%0d exp=0", q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mips_regfile_wb.md
Name: mips_regfile_wb

Overview:
- 32-entry, 32-bit MIPS general-purpose register file, the write-back end of the operand path.
- The operand select mux reads from this block; this block decodes the write-back address and stores the result.
- Provides two combinational read ports with same-cycle write-through bypass, so the decode stage sees write-back data without an extra cycle.
- Keeps a per-register pending scoreboard: the issue stage marks a register when a load targets it, and write-back clears the mark. The pipeline uses this to stall on load-use hazards.

Parameters:
- DATA_W, 32, register width in bits.
- NREG, 32, number of registers.
- ADDR_W, 5, register address width; NREG must equal 2**ADDR_W.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- rs_addr  input  ADDR_W  read port A address.
- rt_addr  input  ADDR_W  read port B address.
- rs_data  output  DATA_W  read port A data, combinational.
- rt_data  output  DATA_W  read port B data, combinational.
- wb_en  input  1  write-back strobe.
- wb_addr  input  ADDR_W  write-back destination register.
- wb_data  input  DATA_W  write-back data.
- pend_set  input  1  issue stage marks a register as awaiting a load result.
- pend_addr  input  ADDR_W  register to mark.
- rs_pending  output  1  the register on read port A is not yet valid.
- rt_pending  output  1  the register on read port B is not yet valid.
- pend_any  output  1  OR of all scoreboard bits (drain/flush status).

Behaviour:
- Clock and reset: one clock, clk. Reset rst_n is asynchronous and active-low.
- Reset effect: while rst_n=0, all registers are 0 and all scoreboard bits are 0, immediately and without waiting for a clock edge. Outputs during reset: rs_data=rt_data=0 (unless the bypass is active), rs_pending=rt_pending=pend_any=0.
- Reset mid-operation: if rst_n asserts in the same cycle as wb_en or pend_set, that write or mark is lost.
- Register 0: always reads 0. Writes to it are ignored. It is never marked pending; pend_set with pend_addr=0 does nothing.
- Write: on the rising edge of clk, when wb_en=1 and wb_addr!=0, reg[wb_addr] takes wb_data. Latency 1 cycle into storage.
- Read: rs_data = (rs_addr==0) ? 0 : bypass ? wb_data : reg[rs_addr]. Here bypass = wb_en && wb_addr==rs_addr. rt_data follows the same rule. Read latency is 0 cycles.
- Both read ports may address the same register. Both may be bypassed in the same cycle.
- Scoreboard next state, per register i != 0:
  - set when pend_set && pend_addr==i;
  - otherwise cleared when wb_en && wb_addr==i;
  - otherwise held.
- Simultaneous set and clear of the same register: set wins. This models a new load issued while an older write to the same register retires. The written data is still stored.
- Pending outputs: rs_pending = pend[rs_addr] && !(wb_en && wb_addr==rs_addr). A pending register being written back this cycle reads as not pending, because the bypass supplies the value. rt_pending follows the same rule.
- pend_set in the current cycle does not affect rs_pending or rt_pending until the next cycle.
- pend_any: registered OR of the scoreboard bits. It reflects the state after the edge, with no bypass term.
- No X propagation: every address value in 0..31 is legal, and no range checking is needed.

Test Plan:
1. Reset and zero register: assert rst_n=0 mid-cycle after writing reg5=0xDEADBEEF. Storage clears immediately, so rs_addr=5 gives rs_data=0 and pend_any=0. Then wb_en=1, wb_addr=0, wb_data=0xFFFFFFFF; the next cycle rs_addr=0 gives 0.
2. Write then read: write reg7=0x12345678 in cycle n. In cycle n+1 with wb_en=0, rs_addr=rt_addr=7 gives both ports 0x12345678.
3. Bypass: reg9 holds 0x1. In the same cycle drive wb_en=1, wb_addr=9, wb_data=0xA5A5A5A5 and rt_addr=9; rt_data=0xA5A5A5A5 combinationally. rs_addr=10 still reads the stored reg10.
4. Load-use stall: pend_set=1, pend_addr=3. The next cycle rs_addr=3 gives rs_pending=1 and pend_any=1. The cycle after, wb_en=1, wb_addr=3, wb_data=0x42 gives rs_pending=0 and rs_data=0x42 in that cycle. After the edge, pend_any=0.
5. Set/clear collision: reg4 is pending. In one cycle drive pend_set=1, pend_addr=4 and wb_en=1, wb_addr=4, wb_data=0x77. After the edge reg4=0x77 and rs_addr=4 gives rs_pending=1.
6. Exhaustive sweep: write reg[i]=i*0x01010101 for i=1..31, then read all 31 on both ports and compare. Mark all 31 pending, check pend_any=1, clear them one by one, and check pend_any=0 only after the last clear.
